toggle_strobe_tx: RTL

- Sending end of the toggle-based clock-crossing strobe protocol; the receiving end turns each polarity change on `flop` into a one-cycle strobe.
- Accepts word/strobe pairs in the local clk domain and buffers them in a small FIFO.
- Issues each word by holding `req_data` stable and toggling `req_flop`, then waits for the receiver's returned ack toggle before issuing the next word.
- Sits at every point where a strobe plus payload must cross into another clock domain.

---
 rtl/toggle_strobe_tx_if.sv | 26 ++
 rtl/toggle_strobe_tx.sv | 152 +++++++++++++++
 2 files changed

// File: rtl/toggle_strobe_tx_if.sv
// Signal bundle between a producer/receiver environment and toggle_strobe_tx.
// The master side supplies strobes and the returned ack toggle.
// The slave side (the transmitter) reports FIFO space, the request toggle/payload and status.
interface toggle_strobe_tx_if #(
    parameter int WIDTH = 8
);
    logic             in_strobe;
    logic [WIDTH-1:0] in_data;
    logic             ready;
    logic             req_flop;
    logic [WIDTH-1:0] req_data;
    logic             ack_flop;
    logic             busy;
    logic             dropped;
    logic [7:0]       drop_count;

    modport master (
        output in_strobe, in_data, ack_flop,
        input  ready, req_flop, req_data, busy, dropped, drop_count
    );

    modport slave (
        input  in_strobe, in_data, ack_flop,
        output ready, req_flop, req_data, busy, dropped, drop_count
    );
endinterface

// File: rtl/toggle_strobe_tx.sv
// Sending end of a toggle-based clock-crossing strobe.
// Words are buffered in a small FIFO. Each word is issued by loading req_data and
// flipping req_flop. The next word waits until the synchronized ack toggle matches req_flop.
module toggle_strobe_tx #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4,
    parameter int SYNC  = 2
) (
    input  logic              clk,
    input  logic              reset,
    toggle_strobe_tx_if.slave bus
);
    localparam int AW  = $clog2(DEPTH);
    localparam int CW  = AW + 1;
    localparam int SCW = $clog2(SYNC + 1);

    typedef enum logic [1:0] {SETTLE, IDLE, WAIT_ACK} state_t;

    state_t           state, state_next;
    logic [SYNC-1:0]  sync_q;
    logic             ack_s;
    logic [SCW-1:0]   settle_cnt;
    logic             settle_done;
    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr, rd_ptr;
    logic [CW-1:0]    count;
    logic             full, empty;
    logic             push, pop, drop;

    assign ack_s = sync_q[SYNC-1];
    assign full  = (count == CW'(DEPTH));
    assign empty = (count == '0);
    // Acceptance looks only at the count at the start of the cycle, so a pop
    // in the same cycle never rescues a strobe that arrives while full.
    assign push  = bus.in_strobe && !full;
    assign drop  = bus.in_strobe && full;

    assign bus.ready = !full;
    assign bus.busy  = !empty || (state != IDLE);

    // Bring the asynchronous ack toggle into the clk domain.
    always_ff @(posedge clk) begin
        // NOTE: registers use <= so every stage samples the pre-edge value of the previous stage.
        if (reset) begin
            sync_q <= '0;
        end else begin
            sync_q[0] <= bus.ack_flop;
            for (int i = 1; i < SYNC; i++) begin
                sync_q[i] <= sync_q[i-1];
            end
        end
    end

    // State register.
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= SETTLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state logic and the pop/settle decisions.
    always_comb begin
        // NOTE: every output of this block gets a default first, so no path leaves one unassigned (no latch).
        state_next  = state;
        pop         = 1'b0;
        settle_done = 1'b0;
        case (state)
            SETTLE: begin
                if (settle_cnt == SCW'(SYNC)) begin
                    settle_done = 1'b1;
                    state_next  = IDLE;
                end
            end
            IDLE: begin
                if (!empty) begin
                    pop        = 1'b1;
                    state_next = WAIT_ACK;
                end
            end
            WAIT_ACK: begin
                if (ack_s == bus.req_flop) begin
                    state_next = IDLE;
                end
            end
            default: state_next = SETTLE;
        endcase
    end

    // Count the SYNC+1 cycles needed for the synchronizer to hold a real ack value.
    always_ff @(posedge clk) begin
        if (reset) begin
            settle_cnt <= '0;
        end else if (state == SETTLE && !settle_done) begin
            settle_cnt <= settle_cnt + SCW'(1);
        end
    end

    // FIFO storage.
    always_ff @(posedge clk) begin
        // NOTE: the storage array is not reset; pointers and count alone define which entries are valid.
        if (push) begin
            mem[wr_ptr] <= bus.in_data;
        end
    end

    // FIFO pointers and occupancy. Pointers wrap naturally because DEPTH is a power of 2.
    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            count <= count + CW'(push) - CW'(pop);
        end
    end

    // Request toggle and payload.
    // At the end of SETTLE, req_flop adopts the receiver's current ack level so that
    // a receiver that was not reset is not seen as owing an ack.
    always_ff @(posedge clk) begin
        if (reset) begin
            bus.req_flop <= 1'b0;
            bus.req_data <= '0;
        end else if (settle_done) begin
            bus.req_flop <= ack_s;
        end else if (pop) begin
            bus.req_flop <= ~bus.req_flop;
            bus.req_data <= mem[rd_ptr];
        end
    end

    // Drop pulse and saturating drop counter.
    always_ff @(posedge clk) begin
        if (reset) begin
            bus.dropped    <= 1'b0;
            bus.drop_count <= '0;
        end else begin
            bus.dropped <= drop;
            if (drop && bus.drop_count != 8'hFF) begin
                bus.drop_count <= bus.drop_count + 8'd1;
            end
        end
    end
endmodule
